// File: rtl/capture_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// capture_ctrl_pkg
//   Shared definitions for the capture RAM write controller.
//   - cap_state_e : controller state encoding
//   - CAP_ADDR_W  : default RAM address width
//   - CAP_DEPTH   : default RAM depth in words
//   - clamp_len() : maps a requested capture length onto 1..depth
// -----------------------------------------------------------------------------
package capture_ctrl_pkg;

    localparam int CAP_ADDR_W = 10;
    localparam int CAP_DEPTH  = 2 ** CAP_ADDR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_e;

    // A length of 0, or anything beyond the RAM depth, means "fill the RAM".
    function automatic logic [31:0] clamp_len(input logic [31:0] len_in,
                                              input logic [31:0] depth);
        if ((len_in == 32'd0) || (len_in > depth)) begin
            return depth;
        end
        return len_in;
    endfunction

endpackage

// File: rtl/capture_sample_filter.sv
// -----------------------------------------------------------------------------
// capture_sample_filter
//   Selects which stream samples get written during a capture: a sample must
//   be valid and on the latched channel, and then only 1 of every decim+1 such
//   matches is kept. The first match after a clear is always kept.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clear      arm-edge pulse: latch ch_sel/decim, restart decimation count
//   ch_sel     channel to capture (sampled on clear)
//   decim      decimation factor minus one (sampled on clear)
//   enable     controller is accepting samples this cycle
//   in_valid   stream sample valid
//   in_ch      stream channel index
//   keep       combinational: write the current sample
// -----------------------------------------------------------------------------
module capture_sample_filter #(
    parameter int CH_W  = 8,
    parameter int DEC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CH_W-1:0]  ch_sel,
    input  logic [DEC_W-1:0] decim,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [CH_W-1:0]  in_ch,
    output logic             keep
);

    logic [CH_W-1:0]  ch_q;
    logic [DEC_W-1:0] decim_q;
    logic [DEC_W-1:0] dec_cnt;
    logic             match;

    assign match = enable & in_valid & (in_ch == ch_q);
    // Count 0 marks a kept match; the counter only moves on matches.
    assign keep  = match & (dec_cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q    <= '0;
            decim_q <= '0;
            dec_cnt <= '0;
        end else if (clear) begin
            ch_q    <= ch_sel;
            decim_q <= decim;
            dec_cnt <= '0;
        end else if (match) begin
            dec_cnt <= (dec_cnt == decim_q) ? '0 : dec_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/capture_write_ctrl.sv
// -----------------------------------------------------------------------------
// capture_write_ctrl
//   Drives port A of the capture pixel RAM. An arm rising edge starts a
//   capture (immediately, or after trig when trig_en is set); kept samples of
//   the selected channel are written at consecutive addresses until len words
//   are stored, then done is raised and held until the next arm edge. Dropping
//   arm while busy aborts. All outputs are registered.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   arm                 level; rising edge starts, low level aborts
//   trig_en, trig       wait-for-trigger select, external trigger
//   len                 words to capture (0 or > depth means depth)
//   ch_sel, decim       channel select, keep 1 of decim+1 matches
//   in_valid/ch/data    channelised sample stream
//   bram_we, bram_en_a  port-A write enable / enable
//   bram_addr           port-A address (low bits of wr_count)
//   bram_wr_data        port-A write data
//   busy, done          in ARMED/CAPTURE; sticky capture complete
//   wr_count            words written in the current or last capture
// -----------------------------------------------------------------------------
module capture_write_ctrl
    import capture_ctrl_pkg::*;
#(
    parameter int ADDR_W = CAP_ADDR_W,
    parameter int DATA_W = 32,
    parameter int CH_W   = 8,
    parameter int DEC_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              trig_en,
    input  logic              trig,
    input  logic [ADDR_W:0]   len,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [DEC_W-1:0]  decim,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    output logic              bram_we,
    output logic              bram_en_a,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count
);

    localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

    cap_state_e      state, state_next;
    logic            arm_q;
    logic [ADDR_W:0] len_q;
    logic            arm_edge;
    logic            start;
    logic            filt_en;
    logic            keep;

    assign arm_edge = arm & ~arm_q;
    assign start    = arm_edge & ((state == IDLE) || (state == DONE));
    // Once the last word is registered, wr_count already equals len_q in the
    // following cycle; gating here drops matches arriving after the final one.
    assign filt_en  = (state == CAPTURE) & arm & (wr_count != len_q);

    capture_sample_filter #(
        .CH_W  (CH_W),
        .DEC_W (DEC_W)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .clear    (start),
        .ch_sel   (ch_sel),
        .decim    (decim),
        .enable   (filt_en),
        .in_valid (in_valid),
        .in_ch    (in_ch),
        .keep     (keep)
    );

    // NOTE: state_next gets a default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (arm_edge) state_next = trig_en ? ARMED : CAPTURE;
            end
            ARMED: begin
                if (!arm)      state_next = IDLE;
                else if (trig) state_next = CAPTURE;
            end
            CAPTURE: begin
                if (!arm)                  state_next = IDLE;
                else if (wr_count == len_q) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            arm_q        <= 1'b1;  // arm held through reset must not start a capture
            len_q        <= '0;
            bram_we      <= 1'b0;
            bram_en_a    <= 1'b0;
            bram_addr    <= '0;
            bram_wr_data <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            wr_count     <= '0;
        end else begin
            state     <= state_next;
            arm_q     <= arm;
            // busy/done follow the registered state so they align with it.
            busy      <= (state_next == ARMED) || (state_next == CAPTURE);
            done      <= (state_next == DONE);
            bram_we   <= keep;
            bram_en_a <= keep;
            if (start) begin
                len_q    <= (ADDR_W+1)'(clamp_len(32'(len), DEPTH));
                wr_count <= '0;
            end else if (keep) begin
                bram_addr    <= wr_count[ADDR_W-1:0];
                bram_wr_data <= in_data;
                wr_count     <= wr_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_capture_write_ctrl.sv
module tb_capture_write_ctrl;
    import capture_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm, trig_en, trig;
    logic [10:0] len;
    logic [7:0]  ch_sel, decim;
    logic        in_valid;
    logic [7:0]  in_ch;
    logic [31:0] in_data;
    logic        bram_we, bram_en_a;
    logic [9:0]  bram_addr;
    logic [31:0] bram_wr_data;
    logic        busy, done;
    logic [10:0] wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0]  wa[$];
    logic [31:0] wd[$];

    capture_write_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .trig_en      (trig_en),
        .trig         (trig),
        .len          (len),
        .ch_sel       (ch_sel),
        .decim        (decim),
        .in_valid     (in_valid),
        .in_ch        (in_ch),
        .in_data      (in_data),
        .bram_we      (bram_we),
        .bram_en_a    (bram_en_a),
        .bram_addr    (bram_addr),
        .bram_wr_data (bram_wr_data),
        .busy         (busy),
        .done         (done),
        .wr_count     (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        arm, trig_en, trig;
        logic [10:0] len;
        logic [7:0]  ch_sel, decim;
        logic        in_valid;
        logic [7:0]  in_ch;
        logic [31:0] in_data;
        logic        e_we;
        logic [9:0]  e_addr;
        logic [31:0] e_data;
        logic        e_busy, e_done;
        logic [10:0] e_cnt;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t v(input logic a, te, tg, input logic [10:0] l,
                               input logic [7:0] cs, dc, input logic vl,
                               input logic [7:0] ic, input logic [31:0] d,
                               input logic ew, input logic [9:0] ea,
                               input logic [31:0] ed, input logic eb, edn,
                               input logic [10:0] ec);
        vec_t r;
        r.arm = a; r.trig_en = te; r.trig = tg; r.len = l; r.ch_sel = cs;
        r.decim = dc; r.in_valid = vl; r.in_ch = ic; r.in_data = d;
        r.e_we = ew; r.e_addr = ea; r.e_data = ed; r.e_busy = eb;
        r.e_done = edn; r.e_cnt = ec;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; outputs are sampled 1 ns after the edge and port-A writes logged.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (bram_we === 1'b1) begin
            wa.push_back(bram_addr);
            wd.push_back(bram_wr_data);
        end
    endtask

    task automatic full_run(input logic [10:0] l, input logic [31:0] seed);
        int bad;
        arm = 1'b0; in_valid = 1'b0; cycle();
        arm = 1'b1; trig_en = 1'b0; len = l; ch_sel = 8'd1; decim = 8'd0;
        cycle();
        wa.delete(); wd.delete();
        for (int i = 0; i < 1030; i++) begin
            in_valid = 1'b1; in_ch = 8'd1; in_data = seed ^ 32'(i);
            cycle();
        end
        in_valid = 1'b0;
        bad = 0;
        for (int k = 0; k < wa.size(); k++) begin
            if (wa[k] !== 10'(k) || wd[k] !== (seed ^ 32'(k))) bad++;
        end
        check($sformatf("full_len%0d_writes", l), 64'(wa.size()), 64'(CAP_DEPTH));
        check($sformatf("full_len%0d_bad", l), 64'(bad), 64'd0);
        check($sformatf("full_len%0d_done", l), 64'(done), 64'd1);
        check($sformatf("full_len%0d_cnt", l), 64'(wr_count), 64'(CAP_DEPTH));
        arm = 1'b0; cycle();
    endtask

    initial begin
        int bad;
        int n_keep;

        // Reset with arm held high.
        rst = 1'b1; arm = 1'b1; trig_en = 1'b0; trig = 1'b0; len = 11'd4;
        ch_sel = 8'd0; decim = 8'd0; in_valid = 1'b0; in_ch = 8'd0; in_data = '0;
        cycle(); cycle();
        check("rst_we", 64'(bram_we), 64'd0);
        check("rst_en", 64'(bram_en_a), 64'd0);
        check("rst_addr", 64'(bram_addr), 64'd0);
        check("rst_data", 64'(bram_wr_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cnt", 64'(wr_count), 64'd0);
        rst = 1'b0;
        in_valid = 1'b1; in_ch = 8'd0; in_data = 32'h55;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (busy !== 1'b0 || bram_we !== 1'b0) bad++;
        end
        check("arm_held_no_start", 64'(bad), 64'd0);
        arm = 1'b0; in_valid = 1'b0; cycle();

        // Table: trigger mode, then restart from DONE in immediate mode.
        tbl[0]  = v(1,1,0,2,5,0, 1,5,'h10, 0,0,0,     1,0,0);
        tbl[1]  = v(1,1,0,2,5,0, 1,5,'h11, 0,0,0,     1,0,0);
        tbl[2]  = v(1,1,1,2,5,0, 1,5,'h12, 0,0,0,     1,0,0);
        tbl[3]  = v(1,1,0,2,5,0, 1,4,'h13, 0,0,0,     1,0,0);
        tbl[4]  = v(1,1,0,2,5,0, 1,5,'h14, 1,0,'h14,  1,0,1);
        tbl[5]  = v(1,1,0,2,5,0, 0,5,'h15, 0,0,0,     1,0,1);
        tbl[6]  = v(1,1,0,2,5,0, 1,5,'h16, 1,1,'h16,  1,0,2);
        tbl[7]  = v(1,1,0,2,5,0, 1,5,'h17, 0,0,0,     0,1,2);
        tbl[8]  = v(1,1,1,2,5,0, 1,5,'h18, 0,0,0,     0,1,2);
        tbl[9]  = v(0,1,0,2,5,0, 1,5,'h19, 0,0,0,     0,1,2);
        tbl[10] = v(1,0,0,1,5,0, 1,5,'h20, 0,0,0,     1,0,0);
        tbl[11] = v(1,0,0,1,5,0, 1,5,'h21, 1,0,'h21,  1,0,1);
        tbl[12] = v(1,0,0,1,5,0, 1,5,'h22, 0,0,0,     0,1,1);
        tbl[13] = v(0,0,0,1,5,0, 0,5,'h23, 0,0,0,     0,1,1);
        for (int r = 0; r < 14; r++) begin
            arm = tbl[r].arm; trig_en = tbl[r].trig_en; trig = tbl[r].trig;
            len = tbl[r].len; ch_sel = tbl[r].ch_sel; decim = tbl[r].decim;
            in_valid = tbl[r].in_valid; in_ch = tbl[r].in_ch; in_data = tbl[r].in_data;
            cycle();
            check($sformatf("row%0d_we", r), 64'(bram_we), 64'(tbl[r].e_we));
            check($sformatf("row%0d_en", r), 64'(bram_en_a), 64'(tbl[r].e_we));
            check($sformatf("row%0d_busy", r), 64'(busy), 64'(tbl[r].e_busy));
            check($sformatf("row%0d_done", r), 64'(done), 64'(tbl[r].e_done));
            check($sformatf("row%0d_cnt", r), 64'(wr_count), 64'(tbl[r].e_cnt));
            if (tbl[r].e_we) begin
                check($sformatf("row%0d_addr", r), 64'(bram_addr), 64'(tbl[r].e_addr));
                check($sformatf("row%0d_data", r), 64'(bram_wr_data), 64'(tbl[r].e_data));
            end
        end
        trig = 1'b0;

        // Immediate capture: ch 0..7 repeating, data = cycle index.
        arm = 1'b1; trig_en = 1'b0; len = 11'd4; ch_sel = 8'd3; decim = 8'd0;
        in_valid = 1'b0;
        cycle();
        check("imm_busy", 64'(busy), 64'd1);
        check("imm_done_cleared", 64'(done), 64'd0);
        wa.delete(); wd.delete();
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1; in_ch = 8'(i % 8); in_data = 32'(i);
            cycle();
            if (i == 27) check("imm_done_early", 64'(done), 64'd0);
            if (i == 28) begin
                check("imm_done", 64'(done), 64'd1);
                check("imm_busy_off", 64'(busy), 64'd0);
            end
        end
        check("imm_cnt", 64'(wr_count), 64'd4);
        check("imm_writes", 64'(wa.size()), 64'd4);
        bad = 0;
        for (int k = 0; k < wa.size(); k++) begin
            if (wa[k] !== 10'(k) || wd[k] !== 32'(3 + 8 * k)) bad++;
        end
        check("imm_contents", 64'(bad), 64'd0);
        in_valid = 1'b0; arm = 1'b0; cycle();

        // Decimation: keep 1 of 3, expect 0, 3, 6.
        arm = 1'b1; len = 11'd3; ch_sel = 8'd3; decim = 8'd2;
        cycle();
        wa.delete(); wd.delete();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_ch = 8'd3; in_data = 32'(i);
            cycle();
        end
        check("dec_writes", 64'(wa.size()), 64'd3);
        bad = 0;
        for (int k = 0; k < wa.size(); k++) begin
            if (wa[k] !== 10'(k) || wd[k] !== 32'(3 * k)) bad++;
        end
        check("dec_contents", 64'(bad), 64'd0);
        check("dec_cnt", 64'(wr_count), 64'd3);
        check("dec_done", 64'(done), 64'd1);
        in_valid = 1'b0; arm = 1'b0; cycle();

        // Full depth: len 0 and an over-range length both mean 1024.
        full_run(11'd0, 32'hA5A5_0000);
        full_run(11'd2047, 32'h0F0F_0000);

        // Abort after 5 of 10 writes.
        arm = 1'b1; len = 11'd10; ch_sel = 8'd2; decim = 8'd0; in_valid = 1'b0;
        cycle();
        wa.delete(); wd.delete();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_ch = 8'd2; in_data = 32'(100 + i);
            cycle();
            if (wr_count == 11'd5) break;
        end
        check("abort_reached_5", 64'(wr_count), 64'd5);
        arm = 1'b0;
        cycle();
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_we", 64'(bram_we), 64'd0);
        check("abort_cnt", 64'(wr_count), 64'd5);
        for (int i = 0; i < 4; i++) cycle();
        check("abort_no_more_writes", 64'(wa.size()), 64'd5);
        check("abort_cnt_hold", 64'(wr_count), 64'd5);
        arm = 1'b1; in_valid = 1'b0;
        cycle();
        check("rearm_busy", 64'(busy), 64'd1);
        check("rearm_cnt", 64'(wr_count), 64'd0);
        in_valid = 1'b1; in_ch = 8'd2; in_data = 32'hBEEF;
        cycle();
        check("rearm_we", 64'(bram_we), 64'd1);
        check("rearm_addr", 64'(bram_addr), 64'd0);
        check("rearm_data", 64'(bram_wr_data), 64'hBEEF);

        // Reset in the middle of that capture.
        cycle(); cycle();
        check("pre_rst_cnt", 64'(wr_count), 64'd3);
        rst = 1'b1;
        #1;
        check("midrst_we", 64'(bram_we), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_cnt", 64'(wr_count), 64'd0);
        cycle();
        rst = 1'b0;
        wa.delete(); wd.delete();
        n_keep = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (busy !== 1'b0) n_keep++;
        end
        check("post_rst_no_writes", 64'(wa.size()), 64'd0);
        check("post_rst_idle", 64'(n_keep), 64'd0);
        arm = 1'b0; cycle();
        arm = 1'b1; cycle();
        check("post_rst_rearm_busy", 64'(busy), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/capture_write_ctrl.md
Name: capture_write_ctrl

Overview:
- Sequences port-A writes into one 1024 x 32 capture pixel RAM block. Software reads that RAM back on port B.
- Software arms a capture and selects one channel from the channelised pixel stream. The block then writes a run of matching (optionally decimated) samples at consecutive addresses and raises a sticky done flag.
- The capture can start immediately on arm or wait for an external trigger.

Parameters:
- ADDR_W, 10, RAM address width; depth = 2**ADDR_W.
- DATA_W, 32, RAM / sample data width.
- CH_W, 8, channel index width.
- DEC_W, 8, decimation field width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- arm  in  1  software level; a rising edge starts a capture, a low level aborts one.
- trig_en  in  1  1 = wait for trig after arm; 0 = capture immediately.
- trig  in  1  external trigger, single-cycle or level.
- len  in  ADDR_W+1  number of words to capture; 0 or >1024 means 1024.
- ch_sel  in  CH_W  channel to capture.
- decim  in  DEC_W  keep 1 of every decim+1 matching samples.
- in_valid  in  1  stream sample valid.
- in_ch  in  CH_W  stream channel index.
- in_data  in  DATA_W  stream sample.
- bram_we  out  1  RAM write enable (port A).
- bram_en_a  out  1  RAM enable (port A).
- bram_addr  out  ADDR_W  RAM address.
- bram_wr_data  out  DATA_W  RAM write data.
- busy  out  1  in ARMED or CAPTURE.
- done  out  1  sticky; capture complete.
- wr_count  out  ADDR_W+1  words written in the current or last capture.

Behaviour:
- Reset: state IDLE; all outputs 0; arm_q resets to 1, so arm held high through reset does not start a capture (a fresh rising edge is required).
- Arm edge: arm & ~arm_q. Accepted only in IDLE or DONE.
  - Latches len (clamped), ch_sel, decim and trig_en.
  - Clears done, wr_count and the decimation counter.
  - Next state: ARMED if trig_en = 1, else CAPTURE.
- States:
  - IDLE.
  - ARMED: waits for trig = 1; goes to CAPTURE on the next cycle. A sample present in the trig cycle is not captured.
  - CAPTURE: writes accepted samples.
  - DONE: holds done = 1 until the next arm edge.
- Match: in_valid & (in_ch == latched ch_sel), evaluated in CAPTURE only.
- Decimation:
  - The first match after entering CAPTURE is always kept.
  - After that, every (decim+1)-th match is kept; the counter advances only on matches.
  - decim = 0 keeps every match.
- Write timing:
  - Kept sample in cycle N -> cycle N+1 has bram_we = bram_en_a = 1, bram_addr = wr_count (pre-increment), bram_wr_data = in_data.
  - wr_count increments in that same cycle. Latency is 1 cycle; all outputs are registered.
- Termination:
  - When the incremented wr_count equals the latched length, the state goes to DONE in that same write cycle; done = 1 and busy = 0 from cycle N+2.
  - Matches arriving after the final kept sample are ignored.
- Idle outputs: bram_we and bram_en_a are 0 outside write cycles; bram_addr and bram_wr_data hold their last values.
- Address wrap: bram_addr = wr_count[ADDR_W-1:0]. At len = 1024 the last write goes to address 1023; addresses never wrap within one capture.
- Abort: arm = 0 while in ARMED or CAPTURE -> IDLE next cycle.
  - A write already registered still completes.
  - done stays 0; wr_count holds the partial count.
- Simultaneous events:
  - Arm edge while in ARMED or CAPTURE is impossible, because arm is already high.
  - Arm edge while in DONE restarts the capture.
  - Trig while in IDLE, CAPTURE or DONE is ignored.
- Reset mid-capture: immediate return to IDLE, outputs 0; no further writes.

Decomposition:
- Package capture_ctrl_pkg holds:
  - state enum {IDLE, ARMED, CAPTURE, DONE};
  - CAP_DEPTH = 2**ADDR_W;
  - a length-clamp function.
- One sub-module, capture_sample_filter, holds the channel match and decimation counter. Its output is a keep pulse; it has a clear input driven by the arm edge.

Test Plan:
- Immediate capture: trig_en = 0, len = 4, ch_sel = 3, decim = 0; stream ch 0..7 repeating, data = cycle index -> addresses 0..3 written with the four ch3 samples; done = 1 two cycles after the 4th match; wr_count = 4.
- Decimation: len = 3, decim = 2, every sample ch = 3 with data 0,1,2,... -> RAM[0..2] = 0, 3, 6.
- Trigger: trig_en = 1; matches during ARMED are not written; trig pulse at cycle T -> first write is for the first match at T+1 or later; a match in cycle T itself is not written.
- Full depth: len = 0 -> 1024 writes at addresses 0..1023, no wrap; done = 1; wr_count = 1024.
- Abort: arm dropped after 5 of len = 10 writes -> IDLE; done = 0; wr_count = 5; no further bram_we; re-arm restarts at address 0.
- Reset: arm high through reset release -> no capture until arm goes low then high; assert rst mid-capture -> bram_we = 0 immediately, busy = 0.
